// File: rtl/unidade_busca.sv
// Instruction-fetch stage for the multi-cycle decode/control datapath.
//
// Owns the program counter. Reads one instruction word at a time from instruction
// memory over a req/ack handshake. Hands the word and its PC to decode over a
// valid/ready handshake. Computes the next PC once the datapath reports the branch
// outcome.
//
// Ports:
//   clk_i          system clock; all state updates on the rising edge
//   rst_i          synchronous, active-high reset
//   start_i        begin fetching; only acted on in IDLE or HALT
//   imem_req_o     read request to instruction memory
//   imem_addr_o    byte address of the requested word (always the current pc)
//   imem_ack_i     memory returns imem_rdata_i this cycle
//   imem_rdata_i   instruction word
//   inst_valid_o   inst_o / inst_pc_o valid toward decode
//   inst_ready_i   decode accepts the instruction
//   inst_o         fetched instruction
//   inst_pc_o      address of inst_o
//   pc_upd_i       one-cycle pulse: datapath done, next PC may be computed
//   branch_taken_i sampled with pc_upd_i
//   branch_off_i   signed byte offset, used when branch_taken_i = 1
//   pc_o           current program counter
//   halted_o       the all-zero halt instruction was fetched
//   fault_o        misaligned or out-of-range fetch target; sticky until reset
module unidade_busca #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o,
  input  logic        pc_upd_i,
  input  logic        branch_taken_i,
  input  logic [12:0] branch_off_i,
  output logic [31:0] pc_o,
  output logic        halted_o,
  output logic        fault_o
);

  localparam logic [31:0] MemBytes = 32'(MEM_WORDS * 4);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StHold,
    StWaitPc,
    StHalt,
    StFault
  } state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        req_q;
  logic        valid_q;
  logic        halted_q;
  logic        fault_q;

  logic [31:0] target;
  logic        target_bad;

  // Next-PC candidate is always relative to the instruction just retired.
  // A negative offset that wraps below zero lands far above MemBytes and is
  // therefore caught by the range check.
  always_comb begin
    target = '0;
    if (branch_taken_i) begin
      target = inst_pc_q + {{19{branch_off_i[12]}}, branch_off_i};
    end else begin
      target = inst_pc_q + 32'd4;
    end
    target_bad = (target[1:0] != 2'b00) || (target >= MemBytes);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      inst_pc_q <= '0;
      req_q     <= 1'b0;
      valid_q   <= 1'b0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            req_q   <= 1'b1;
            state_q <= StReq;
          end
        end
        StReq: begin
          if (imem_ack_i) begin
            req_q <= 1'b0;
            if (imem_rdata_i == 32'h0) begin
              halted_q <= 1'b1;
              state_q  <= StHalt;
            end else begin
              inst_q    <= imem_rdata_i;
              inst_pc_q <= pc_q;
              valid_q   <= 1'b1;
              state_q   <= StHold;
            end
          end
        end
        StHold: begin
          if (inst_ready_i) begin
            valid_q <= 1'b0;
            state_q <= StWaitPc;
          end
        end
        StWaitPc: begin
          if (pc_upd_i) begin
            if (target_bad) begin
              fault_q <= 1'b1;
              state_q <= StFault;
            end else begin
              pc_q    <= target;
              req_q   <= 1'b1;
              state_q <= StReq;
            end
          end
        end
        StHalt: begin
          if (start_i) begin
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
            req_q    <= 1'b1;
            state_q  <= StReq;
          end
        end
        StFault: begin
          // Terminal until reset.
          req_q <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          req_q   <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign inst_valid_o = valid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = inst_pc_q;
  assign pc_o         = pc_q;
  assign halted_o     = halted_q;
  assign fault_o      = fault_q;

endmodule

// File: tb/tb_unidade_busca.sv
module tb_unidade_busca;

  logic        clk;
  logic        rst;
  logic        start;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        pc_upd;
  logic        branch_taken;
  logic [12:0] branch_off;
  logic [31:0] pc;
  logic        halted;
  logic        fault;

  unidade_busca #(
    .RESET_PC (32'h0),
    .MEM_WORDS(64)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rdata_i  (imem_rdata),
    .inst_valid_o  (inst_valid),
    .inst_ready_i  (inst_ready),
    .inst_o        (inst),
    .inst_pc_o     (inst_pc),
    .pc_upd_i      (pc_upd),
    .branch_taken_i(branch_taken),
    .branch_off_i  (branch_off),
    .pc_o          (pc),
    .halted_o      (halted),
    .fault_o       (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected {inst, inst_pc} pushed when memory returns a word,
  // popped when decode accepts it.
  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } sb_t;
  sb_t sb_q[$];

  always @(posedge clk) begin
    if (!rst && inst_valid && inst_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected_accept", 32'd1, 32'd0);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_inst", inst, e.inst);
        check("sb_inst_pc", inst_pc, e.pc);
      end
    end
  end

  typedef struct {
    bit          pre;    // reset + start before this entry
    logic [31:0] rdata;
    int          waits;  // cycles before ack
    int          rdy;    // cycles inst_ready stays low
    bit          taken;
    logic [12:0] off;
    logic [31:0] ipc;    // expected fetch address / inst_pc
    logic [31:0] epc;    // expected pc after update (or at halt)
    bit          eflt;
    bit          ehalt;
  } vec_t;

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_fault", {31'd0, fault}, 32'd0);
    check("rst_pc", pc, 32'd0);
    check("rst_inst", inst, 32'd0);
    check("rst_inst_pc", inst_pc, 32'd0);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] rdata, input int waits, input logic [31:0] addr);
    int t;
    t = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", {31'd0, imem_req}, 32'd1);
    for (int i = 0; i < waits; i++) begin
      check("addr_hold", imem_addr, addr);
      check("req_hold", {31'd0, imem_req}, 32'd1);
      @(negedge clk);
    end
    check("addr_at_ack", imem_addr, addr);
    imem_ack   = 1'b1;
    imem_rdata = rdata;
    if (rdata != 32'h0) sb_q.push_back('{inst: rdata, pc: addr});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom();
    check("req_drop", {31'd0, imem_req}, 32'd0);
  endtask

  task automatic step(input vec_t v);
    if (v.pre) begin
      do_reset();
      kick();
    end
    fetch(v.rdata, v.waits, v.ipc);
    if (v.ehalt) begin
      check("halt_valid", {31'd0, inst_valid}, 32'd0);
      check("halt_flag", {31'd0, halted}, 32'd1);
      check("halt_pc", pc, v.epc);
      kick();
      check("restart_halted", {31'd0, halted}, 32'd0);
      check("restart_pc", pc, 32'd0);
      check("restart_req", {31'd0, imem_req}, 32'd1);
      return;
    end
    check("valid", {31'd0, inst_valid}, 32'd1);
    check("inst", inst, v.rdata);
    check("inst_pc", inst_pc, v.ipc);
    for (int i = 0; i < v.rdy; i++) begin
      // A misaligned branch pulse in HOLD would fault if it were not ignored.
      if (i == 0) begin
        pc_upd       = 1'b1;
        branch_taken = 1'b1;
        branch_off   = 13'd2;
      end
      @(negedge clk);
      pc_upd = 1'b0;
      check("hold_valid", {31'd0, inst_valid}, 32'd1);
      check("hold_inst", inst, v.rdata);
      check("hold_pc", pc, v.ipc);
    end
    check("hold_fault", {31'd0, fault}, 32'd0);
    inst_ready = 1'b1;
    @(negedge clk);
    inst_ready = 1'b0;
    check("valid_drop", {31'd0, inst_valid}, 32'd0);
    pc_upd       = 1'b1;
    branch_taken = v.taken;
    branch_off   = v.off;
    @(negedge clk);
    pc_upd = 1'b0;
    check("next_pc", pc, v.epc);
    check("fault", {31'd0, fault}, {31'd0, v.eflt});
    check("next_req", {31'd0, imem_req}, {31'd0, !v.eflt});
    if (v.eflt) begin
      kick();
      @(negedge clk);
      @(negedge clk);
      check("fault_sticky", {31'd0, fault}, 32'd1);
      check("fault_no_req", {31'd0, imem_req}, 32'd0);
      check("fault_pc", pc, v.epc);
    end else begin
      check("next_addr", imem_addr, v.epc);
    end
  endtask

  vec_t vecs[8];
  vec_t v;

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    imem_ack     = 1'b0;
    imem_rdata   = 32'h0;
    inst_ready   = 1'b0;
    pc_upd       = 1'b0;
    branch_taken = 1'b0;
    branch_off   = 13'd0;

    //         pre  rdata         w  rdy tk  off        ipc     epc     flt halt
    vecs[0] = '{1'b1, 32'h00500093, 3, 5, 1'b0, 13'd0,    32'd0,   32'd4,   1'b0, 1'b0};
    vecs[1] = '{1'b0, 32'h00100113, 0, 0, 1'b1, 13'h1ffc, 32'd4,   32'd0,   1'b0, 1'b0};
    vecs[2] = '{1'b0, 32'h00208193, 1, 1, 1'b1, 13'd8,    32'd0,   32'd8,   1'b0, 1'b0};
    vecs[3] = '{1'b0, 32'h00000000, 2, 0, 1'b0, 13'd0,    32'd8,   32'd8,   1'b0, 1'b1};
    vecs[4] = '{1'b0, 32'h00300213, 0, 0, 1'b1, 13'd2,    32'd0,   32'd0,   1'b1, 1'b0};
    vecs[5] = '{1'b1, 32'h00400293, 0, 0, 1'b1, 13'd252,  32'd0,   32'd252, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 32'h00500313, 1, 2, 1'b0, 13'd0,    32'd252, 32'd252, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 32'h00600393, 0, 0, 1'b1, 13'h1ffc, 32'd0,   32'd0,   1'b1, 1'b0};

    for (int i = 0; i < 8; i++) step(vecs[i]);

    // Reset while a request at a nonzero pc is outstanding; a late ack is ignored.
    v = '{1'b1, 32'h00800493, 0, 0, 1'b1, 13'd8, 32'd0, 32'd8, 1'b0, 1'b0};
    step(v);
    check("pre_rst_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    check("midrst_req", {31'd0, imem_req}, 32'd0);
    check("midrst_pc", pc, 32'd0);
    imem_ack   = 1'b1;
    imem_rdata = 32'h00900513;
    @(negedge clk);
    @(negedge clk);
    imem_ack = 1'b0;
    check("late_ack_valid", {31'd0, inst_valid}, 32'd0);
    check("late_ack_req", {31'd0, imem_req}, 32'd0);
    check("late_ack_inst", inst, 32'd0);
    kick();
    check("idle_start_req", {31'd0, imem_req}, 32'd1);
    check("idle_start_addr", imem_addr, 32'd0);

    check("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

endmodule

// File: doc/unidade_busca.md
Name: unidade_busca

Overview:
- Instruction-fetch stage that sits directly upstream of the multi-cycle decode/control datapath.
- Owns the program counter and issues word reads to instruction memory over a req/ack handshake.
- Hands each fetched instruction and its PC to decode over a valid/ready handshake, then computes the next PC once the datapath reports the branch outcome.
- Detects the all-zero halt instruction and bad fetch targets.

Parameters:
RESET_PC, 0, PC loaded on reset and on restart from HALT
MEM_WORDS, 64, instruction memory depth in 32-bit words; fetch address must be < MEM_WORDS*4

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  begin fetching; honoured only in IDLE or HALT
imem_req  output  1  read request to instruction memory
imem_addr  output  32  byte address of requested word, equals pc
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  32  instruction word
inst_valid  output  1  inst/inst_pc valid toward decode
inst_ready  input  1  decode accepts instruction
inst  output  32  fetched instruction
inst_pc  output  32  address of inst
pc_upd  input  1  one-cycle pulse: datapath finished instruction, next PC may be computed
branch_taken  input  1  sampled with pc_upd; take branch
branch_off  input  13  signed byte offset, sampled with pc_upd when branch_taken=1
pc  output  32  current program counter
halted  output  1  zero instruction fetched
fault  output  1  misaligned or out-of-range target; sticky

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE, pc=RESET_PC.
  - imem_req, inst_valid, halted and fault are 0; inst and inst_pc are 0.
  - Reset overrides everything, including an outstanding request; imem_req is low in the cycle after reset.
- States: IDLE, REQ, HOLD, WAIT_PC, HALT, FAULT.
- IDLE:
  - No request is issued.
  - start=1 -> REQ.
- REQ:
  - imem_req=1 and imem_addr=pc, both held stable until imem_ack.
  - On imem_ack with imem_rdata==0 -> HALT; no inst_valid is produced.
  - On imem_ack with imem_rdata!=0: latch inst=imem_rdata and inst_pc=pc; inst_valid=1 from the next cycle -> HOLD.
  - Latency: ack at cycle N gives inst_valid=1 at N+1.
- HOLD:
  - inst_valid=1; inst and inst_pc are held stable.
  - On inst_valid&inst_ready: inst_valid=0 the next cycle -> WAIT_PC.
  - pc_upd in this state is ignored.
- WAIT_PC: waits for pc_upd. On pc_upd:
  - If branch_taken=1, target = inst_pc + sign_extend(branch_off) (32-bit, modulo 2^32).
  - Otherwise, target = inst_pc + 4.
  - If target[1:0]!=0 or target >= MEM_WORDS*4 -> FAULT, and pc is left unchanged.
  - Otherwise pc=target -> REQ. The next imem_req is asserted the cycle after pc_upd.
- HALT:
  - halted=1.
  - start=1 -> pc=RESET_PC, halted=0 -> REQ.
- FAULT:
  - fault=1, imem_req=0.
  - Only rst leaves FAULT; start is ignored.
- imem_ack is ignored outside REQ.
- pc_upd is ignored outside WAIT_PC.
- start is ignored outside IDLE and HALT.
- A negative offset that wraps below 0 produces a huge target, which is reported as an out-of-range FAULT.
- The boundary target MEM_WORDS*4-4 is legal; MEM_WORDS*4 faults.

Test Plan:
- Reset, then start; memory acks after 3 wait cycles with 0x00500093 -> imem_addr=0 held for all 3 cycles; inst_valid=1 the cycle after ack with inst=0x00500093, inst_pc=0.
- inst_ready held low for 5 cycles -> inst_valid and inst stay stable; a pc_upd pulse during HOLD is ignored and pc stays 0.
- Handshake, then pc_upd with branch_taken=0 -> pc=4 and next imem_addr=4; then pc_upd with branch_taken=1 and branch_off=-4 from inst_pc=4 -> pc=0.
- Fetch of 0x00000000 at pc=8 -> halted=1, no inst_valid; start -> pc=RESET_PC, halted=0, imem_req=1.
- Branch with branch_off=2 -> fault=1 with pc unchanged; separately, target 256 with MEM_WORDS=64 -> fault=1; start has no effect until rst.
- rst asserted while in REQ awaiting ack -> imem_req=0 the next cycle, pc=0, state IDLE; a late imem_ack is ignored.
